// File: rtl/uart_buffer_scheduler_if.sv
// Signal bundle between the buffer scheduler, the byte producers, the ring buffer and the UART transmitter.
// The master side is the scheduler; the slave side is everything around it.
interface uart_buffer_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic [NUM_REQ-1:0]        reqAck;
    logic                      bufWriteEnable;
    logic [DATA_W-1:0]         bufWriteData;
    logic                      bufFull;
    logic                      bufReadEnable;
    logic                      bufReadAck;
    logic [DATA_W-1:0]         bufReadData;
    logic                      txStart;
    logic [DATA_W-1:0]         txData;
    logic                      txBusy;

    modport master (
        input  req, reqData, bufFull, bufReadAck, bufReadData, txBusy,
        output reqAck, bufWriteEnable, bufWriteData, bufReadEnable, txStart, txData
    );

    modport slave (
        output req, reqData, bufFull, bufReadAck, bufReadData, txBusy,
        input  reqAck, bufWriteEnable, bufWriteData, bufReadEnable, txStart, txData
    );
endinterface

// File: rtl/uart_buffer_scheduler.sv
// Round-robin producer writes into a single-port UART ring buffer, alternating with reads that
// drain it into the transmitter; the buffer never sees a write and a read in the same cycle.
module uart_buffer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_buffer_scheduler_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, TX_START} stateE;

    stateE             state;
    stateE             nextState;
    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  grantNext;
    logic              lastWasWrite;
    logic              emptyFlag;
    logic [DATA_W-1:0] writeByte;
    logic [DATA_W-1:0] txByte;
    logic [DATA_W-1:0] reqByte [NUM_REQ];
    logic              canWrite;
    logic              canRead;
    logic              takeWrite;
    logic              takeRead;

    for (genvar i = 0; i < NUM_REQ; i++) begin : gUnpack
        assign reqByte[i] = bus.reqData[i*DATA_W +: DATA_W];
    end

    // First requester at or above rrPtr, wrapping at NUM_REQ (not necessarily a power of two).
    always_comb begin : grantSearch
        logic [PTR_W:0] sum;
        logic           found;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        grantNext = rrPtr;
        found     = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rrPtr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            if (!found && bus.req[sum[PTR_W-1:0]]) begin
                found     = 1'b1;
                grantNext = sum[PTR_W-1:0];
            end
        end
    end

    assign canWrite  = (|bus.req) && !bus.bufFull;
    assign canRead   = !emptyFlag && !bus.txBusy;
    assign takeWrite = (state == IDLE) && canWrite && (!canRead || !lastWasWrite);
    assign takeRead  = (state == IDLE) && canRead && !takeWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (takeWrite)     nextState = WRITE;
                else if (takeRead) nextState = RD_REQ;
            end
            WRITE:    nextState = IDLE;
            RD_REQ:   nextState = RD_WAIT;
            RD_WAIT:  nextState = bus.bufReadAck ? TX_START : IDLE;
            TX_START: if (!bus.txBusy) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Strobes decode state only; txStart stays up while the transmitter is busy and is
    // taken on the first cycle it reads txBusy low.
    always_comb begin
        bus.reqAck         = '0;
        bus.bufWriteEnable = (state == WRITE);
        bus.bufReadEnable  = (state == RD_REQ);
        bus.txStart        = (state == TX_START);
        if (state == WRITE) bus.reqAck[grant] = 1'b1;
    end

    assign bus.bufWriteData = writeByte;
    assign bus.txData       = txByte;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rrPtr        <= '0;
            grant        <= '0;
            lastWasWrite <= 1'b0;
            emptyFlag    <= 1'b1;
            writeByte    <= '0;
            txByte       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (takeWrite) begin
                        grant     <= grantNext;
                        writeByte <= reqByte[grantNext];
                    end else if (takeRead) begin
                        lastWasWrite <= 1'b0;
                    end
                end
                WRITE: begin
                    rrPtr        <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    emptyFlag    <= 1'b0;
                    lastWasWrite <= 1'b1;
                end
                RD_WAIT: begin
                    // An empty answer parks reads until the next write refills the buffer.
                    if (bus.bufReadAck) txByte    <= bus.bufReadData;
                    else                emptyFlag <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_buffer_scheduler.sv
// Directed and randomized bench for uart_buffer_scheduler with queue models of the buffer,
// the producers' round-robin service order and the transmitter.
module tb_uart_buffer_scheduler;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int BUF_CAP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_buffer_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
    uart_buffer_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0]         bufQ[$];
    logic [DATA_W-1:0]         sentQ[$];
    int                        tbPtr;
    logic [NUM_REQ-1:0]        prevReq;
    logic [NUM_REQ*DATA_W-1:0] prevData;
    logic                      prevFull;
    int                        txMode;   // 0 auto busy after accept, 1 forced busy, 2 never busy
    int                        prodMode; // 0 directed, 1 random requests, 2 drain only
    bit                        fullAuto;
    int                        busyCnt;
    bit                        sawEmptyRead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rrPick(input int ptr, input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    // Judge the cycle now ending, advance one clock, then drive the environment's answers.
    task automatic step();
        logic                      we, re, ts, busy, curFull, accepted;
        logic [NUM_REQ-1:0]        ack, curReq;
        logic [DATA_W-1:0]         wd, td;
        logic [NUM_REQ*DATA_W-1:0] curData;
        int                        g;
        we = bus.bufWriteEnable; re = bus.bufReadEnable; ts = bus.txStart; busy = bus.txBusy;
        ack = bus.reqAck; wd = bus.bufWriteData; td = bus.txData;
        curReq = bus.req; curData = bus.reqData; curFull = bus.bufFull;

        check("wr_rd_exclusive", we & re, 0);
        if (we || ack != '0) begin
            g = rrPick(tbPtr, prevReq);
            check("write_strobe", we, 1);
            check("write_not_full", prevFull, 0);
            check("req_ack", ack, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                check("write_byte", wd, prevData[g*DATA_W +: DATA_W]);
                sentQ.push_back(prevData[g*DATA_W +: DATA_W]);
                tbPtr = (g + 1) % NUM_REQ;
            end
            if (we && !curFull) bufQ.push_back(wd);
        end
        accepted = ts && !busy;
        if (accepted) begin
            check("tx_has_pending_byte", sentQ.size() > 0, 1);
            if (sentQ.size() > 0) check("tx_byte", td, sentQ.pop_front());
        end

        @(posedge clk); #1;

        if (re && bufQ.size() > 0) begin
            bus.bufReadAck  = 1'b1;
            bus.bufReadData = bufQ.pop_front();
        end else begin
            bus.bufReadAck  = 1'b0;
            bus.bufReadData = DATA_W'($urandom);
            if (re) sawEmptyRead = 1'b1;
        end
        case (txMode)
            1: bus.txBusy = 1'b1;
            2: bus.txBusy = 1'b0;
            default: begin
                if (accepted) busyCnt = $urandom_range(1, 5);
                bus.txBusy = (busyCnt > 0);
                if (busyCnt > 0) busyCnt--;
            end
        endcase
        if (fullAuto) bus.bufFull = (bufQ.size() >= BUF_CAP);
        if (prodMode != 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) bus.req[i] = 1'b0;
                else if (prodMode == 1 && !bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.reqData[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
        end
        prevReq = curReq; prevData = curData; prevFull = curFull;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #1;
        check("rst_outputs", {bus.reqAck, bus.bufWriteEnable, bus.bufReadEnable, bus.txStart,
                              bus.bufWriteData, bus.txData}, 0);
        bus.req = '0; bus.reqData = '0; bus.bufFull = 1'b0; bus.bufReadAck = 1'b0;
        bus.bufReadData = '0; bus.txBusy = 1'b0;
        bufQ.delete(); sentQ.delete();
        tbPtr = 0; prevReq = '0; prevData = '0; prevFull = 1'b0; busyCnt = 0;
        sawEmptyRead = 1'b0; txMode = 2; prodMode = 0; fullAuto = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        int k;
        logic [NUM_REQ-1:0] ackLog[$];
        logic [DATA_W-1:0]  dataLog[$];

        reset = 1'b0;
        bus.req = '0; bus.reqData = '0; bus.bufFull = 1'b0; bus.bufReadAck = 1'b0;
        bus.bufReadData = '0; bus.txBusy = 1'b0;
        #2;
        applyReset();

        // Empty after reset: no reads, no transmit for 20 cycles.
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            cnt += int'(bus.bufReadEnable) + int'(bus.txStart);
        end
        check("t1_idle_after_reset", cnt, 0);

        // One byte from producer 1 through the buffer to the transmitter.
        txMode = 0;
        bus.req = 4'b0010; bus.reqData[15:8] = 8'h41;
        step();
        check("t2_write_en", bus.bufWriteEnable, 1);
        check("t2_write_data", bus.bufWriteData, 8'h41);
        check("t2_req_ack", bus.reqAck, 4'b0010);
        bus.req = '0;
        step(); check("t2_ack_pulse", bus.reqAck, 0);
        step(); check("t2_read_en", bus.bufReadEnable, 1);
        step(); check("t2_read_one_cycle", bus.bufReadEnable, 0);
        step(); check("t2_tx_start", bus.txStart, 1);
        check("t2_tx_data", bus.txData, 8'h41);
        step(); check("t2_tx_drop", bus.txStart, 0);

        // All producers held, transmitter busy: strict round-robin writes, no reads.
        applyReset();
        txMode = 1; bus.txBusy = 1'b1; fullAuto = 1'b0;
        bus.req = 4'b1111; bus.reqData = {8'h13, 8'h12, 8'h11, 8'h10};
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            cnt += int'(bus.bufReadEnable);
            if (bus.reqAck != '0) begin
                ackLog.push_back(bus.reqAck);
                dataLog.push_back(bus.bufWriteData);
            end
        end
        check("t3_no_reads", cnt, 0);
        check("t3_ack_count", ackLog.size() >= 5, 1);
        if (ackLog.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t3_ack_order", ackLog[i], 32'd1 << (i % NUM_REQ));
                check("t3_data_order", dataLog[i], 8'h10 + 8'(i % NUM_REQ));
            end
        end

        // Buffer full blocks writes; producer 0 wins once it clears.
        applyReset();
        txMode = 1; bus.txBusy = 1'b1; fullAuto = 1'b0; bus.bufFull = 1'b1;
        bus.req = 4'b0101; bus.reqData = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            cnt += int'(bus.bufWriteEnable) + int'(bus.reqAck != '0);
        end
        check("t4_full_blocks", cnt, 0);
        bus.bufFull = 1'b0; fullAuto = 1'b1;
        step();
        check("t4_first_ack", bus.reqAck, 4'b0001);
        check("t4_first_data", bus.bufWriteData, 8'hA0);
        bus.req = 4'b0100;
        step(); step();
        check("t4_second_ack", bus.reqAck, 4'b0100);
        check("t4_second_data", bus.bufWriteData, 8'hC2);
        bus.req = '0;

        // An empty read parks reads until the next write, which is followed by a quick read.
        applyReset();
        txMode = 0;
        bus.req = 4'b0001; bus.reqData[7:0] = 8'h5A;
        step();
        check("t5_ack", bus.reqAck, 4'b0001);
        bus.req = '0;
        k = 0;
        while (!sawEmptyRead && k < 40) begin step(); k++; end
        check("t5_empty_read_seen", sawEmptyRead, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin step(); cnt += int'(bus.bufReadEnable); end
        check("t5_no_read_when_empty", cnt, 0);
        bus.req = 4'b0010; bus.reqData[15:8] = 8'h77;
        step();
        check("t5_write", bus.bufWriteEnable, 1);
        bus.req = '0;
        k = 0;
        while (!bus.bufReadEnable && k < 4) begin step(); k++; end
        check("t5_read_within_2", bus.bufReadEnable && k <= 2, 1);

        // Reset while txStart waits on a busy transmitter: the byte is dropped.
        applyReset();
        bus.req = 4'b0001; bus.reqData[7:0] = 8'h33;
        step();
        bus.req = '0;
        k = 0;
        while (!bus.bufReadEnable && k < 6) begin step(); k++; end
        check("t6_read_issued", bus.bufReadEnable, 1);
        step();
        txMode = 1; bus.txBusy = 1'b1;
        step();
        check("t6_tx_start", bus.txStart, 1);
        check("t6_tx_data", bus.txData, 8'h33);
        step();
        check("t6_tx_start_held", bus.txStart, 1);
        applyReset();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            cnt += int'(bus.bufReadEnable) + int'(bus.txStart);
        end
        check("t6_idle_after_reset", cnt, 0);

        // Random producers, small buffer, random transmitter busy time, then drain.
        applyReset();
        txMode = 0; prodMode = 1; fullAuto = 1'b1;
        for (int c = 0; c < 800; c++) step();
        prodMode = 2;
        k = 0;
        while ((bus.req != '0 || sentQ.size() != 0) && k < 400) begin step(); k++; end
        check("rand_all_acked", bus.req, 0);
        check("rand_all_sent", sentQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_buffer_scheduler.md
Name: uart_buffer_scheduler

Overview:
- Sequences the single-port UART byte ring buffer between NUM_REQ byte producers and one UART transmitter.
- Arbitrates producer writes round-robin into the buffer write port.
- Drains the buffer through its read/ack port into the transmitter.
- Never asserts buffer write and read in the same cycle, because the buffer fails any read issued during a write cycle.

Parameters:
NUM_REQ, 4, number of byte producers (2..8)
DATA_W, 8, byte width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-producer request; held with data until reqAck
reqData  in  NUM_REQ*DATA_W  producer i byte at bits [i*DATA_W +: DATA_W]
reqAck  out  NUM_REQ  one-cycle pulse: producer's byte written
bufWriteEnable  out  1  buffer write strobe
bufWriteData  out  DATA_W  buffer write byte
bufFull  in  1  buffer full (a write would be dropped)
bufReadEnable  out  1  buffer read strobe
bufReadAck  in  1  buffer read result, valid the cycle after bufReadEnable (1=data, 0=empty)
bufReadData  in  DATA_W  buffer read byte, valid with bufReadAck=1
txStart  out  1  transmitter start request
txData  out  DATA_W  byte to transmit
txBusy  in  1  transmitter busy; goes high the cycle after an accepted txStart

Behaviour:
- All outputs are registered or decoded from registered state only; no input-to-output combinational paths.
- Reset (async) forces:
  - state IDLE; all strobes and reqAck at 0; data outputs at 0.
  - rrPtr=0, lastWasWrite=0, emptyFlag=1 (buffer is empty after reset).
- States: IDLE, WRITE, RD_REQ, RD_WAIT, TX_START.
- IDLE decision each cycle:
  - canWrite = |req && !bufFull.
  - canRead = !emptyFlag && !txBusy.
  - If canWrite && (!canRead || !lastWasWrite): go to WRITE. Latch grant g = first i with req[i], searching from rrPtr upward with wrap. Latch reqData[g] into bufWriteData.
  - Else if canRead: go to RD_REQ, clear lastWasWrite.
  - Else: stay in IDLE.
- WRITE (1 cycle):
  - bufWriteEnable=1; reqAck[g]=1.
  - rrPtr <= (g+1) mod NUM_REQ (explicit wrap; NUM_REQ need not be a power of 2).
  - emptyFlag <= 0; lastWasWrite <= 1; next state IDLE.
  - Producer changes to req/reqData during WRITE do not affect the latched byte.
- RD_REQ (1 cycle): bufReadEnable=1; next state RD_WAIT.
- RD_WAIT (1 cycle): sample bufReadAck.
  - 1: latch bufReadData into txData; go to TX_START.
  - 0: set emptyFlag=1; go to IDLE. No further reads until the next WRITE.
- TX_START: txStart=1 while txBusy==0; on the first such cycle, go to IDLE and drop txStart next cycle. If txBusy==1, hold.
- Write-to-ack latency: 1 cycle after the IDLE decision. Read-to-txStart: 2 cycles after RD_REQ.
- Fairness:
  - With reads and writes both pending, they alternate write, read, write...
  - Producers are served strictly round-robin; a continuously requesting producer gets at most 1 of every NUM_REQ writes while others are requesting.
- bufFull asserted: no writes, no reqAck; producers hold.
- reqAck is never asserted for a producer whose req was low at the IDLE decision.
- bufWriteEnable and bufReadEnable are mutually exclusive in every cycle.
- Reset mid-operation (any state): immediate return to the reset values. A byte latched in txData but not yet started is discarded.

Test Plan:
- Reset pulse, all inputs 0 -> all outputs 0; bufReadEnable stays 0 for 20 cycles (emptyFlag=1).
- req=0010, reqData[1]=0x41, buffer model returns ack=1/0x41, txBusy=0 -> WRITE with bufWriteData=0x41, reqAck=0010 one cycle; then RD_REQ, RD_WAIT, txStart=1 with txData=0x41 two cycles after bufReadEnable.
- req=1111 held, distinct bytes 0x10..0x13, txBusy=1 -> reqAck sequence 0001, 0010, 0100, 1000, 0001; bufWriteData follows 0x10, 0x11, 0x12, 0x13, 0x10; no reads.
- bufFull=1, req=0101 for 10 cycles -> no bufWriteEnable, no reqAck. Drop bufFull -> producer 0 acked first.
- Buffer model returns bufReadAck=0 -> emptyFlag set; no bufReadEnable until a write; after one write, a read is issued within 2 cycles. Checker confirms write and read strobes are never both high.
- Assert reset during TX_START with txBusy=1 -> txStart=0 in the same cycle; after release, state IDLE and emptyFlag=1.
